// File: rtl/cpsr_flag_unit.sv
// cpsr_flag_unit: N/Z/C/V status register with registered ARM condition evaluation and sticky overflow; define CPSR_FLAG_FORWARD_EN to forward same-cycle flag writes into the condition test
module cpsr_flag_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       Z,
    input  logic       V,
    input  logic       C,
    input  logic       N,
    input  logic       flags_valid,
    input  logic       set_flags,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    input  logic       clear_sticky,
    output logic [3:0] flags,
    output logic       cond_pass,
    output logic       cond_pass_valid,
    output logic       sticky_v
);
    logic       flag_wr;
    logic [3:0] eff;
    logic       n, z, c, v;
    logic       pass;

    assign flag_wr = flags_valid & set_flags;

`ifdef CPSR_FLAG_FORWARD_EN
    assign eff = (flag_wr & cond_valid) ? {N, Z, C, V} : flags;
`else
    assign eff = flags;
`endif

    assign {n, z, c, v} = eff;

    // Decode the ARM condition field against the effective flags
    always_comb begin
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c & !z;
            4'b1001: pass = !c | z;
            4'b1010: pass = n == v;
            4'b1011: pass = n != v;
            4'b1100: pass = !z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Architectural flags, registered condition result and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags           <= 4'b0000;
            cond_pass       <= 1'b0;
            cond_pass_valid <= 1'b0;
            sticky_v        <= 1'b0;
        end else begin
            if (flag_wr) flags <= {N, Z, C, V};
            if (cond_valid) cond_pass <= pass;
            cond_pass_valid <= cond_valid;
            if (flag_wr & V) sticky_v <= 1'b1;
            else if (clear_sticky) sticky_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpsr_flag_unit.sv
// tb_cpsr_flag_unit: directed self-checking bench for cpsr_flag_unit
module tb_cpsr_flag_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Z = 0, V = 0, C = 0, N = 0;
    logic       flags_valid = 0, set_flags = 0, cond_valid = 0, clear_sticky = 0;
    logic [3:0] cond = 4'b0000;
    logic [3:0] flags;
    logic       cond_pass, cond_pass_valid, sticky_v;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] sweep_exp = 16'b0110_0110_1010_0101;
    logic       fwd_exp;

    cpsr_flag_unit dut (
        .clk(clk), .reset(reset), .Z(Z), .V(V), .C(C), .N(N),
        .flags_valid(flags_valid), .set_flags(set_flags), .cond(cond),
        .cond_valid(cond_valid), .clear_sticky(clear_sticky), .flags(flags),
        .cond_pass(cond_pass), .cond_pass_valid(cond_pass_valid), .sticky_v(sticky_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] nzcv, input logic fv, input logic sf);
        {N, Z, C, V} = nzcv;
        flags_valid = fv;
        set_flags = sf;
    endtask

    initial begin
`ifdef CPSR_FLAG_FORWARD_EN
        fwd_exp = 1'b1;
`else
        fwd_exp = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        chk("rst_flags", flags, 4'b0000);
        chk("rst_valid", {3'b0, cond_pass_valid}, 4'b0);

        drive(4'b1111, 1, 1);
        cond = 4'b1110;
        cond_valid = 1;
        step();
        drive(4'b0000, 0, 0);
        chk("pre_flags", flags, 4'b1111);
        chk("pre_pass", {3'b0, cond_pass}, 4'b1);
        chk("pre_sticky", {3'b0, sticky_v}, 4'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_flags", flags, 4'b0000);
        chk("async_pass", {3'b0, cond_pass}, 4'b0);
        chk("async_valid", {3'b0, cond_pass_valid}, 4'b0);
        chk("async_sticky", {3'b0, sticky_v}, 4'b0);
        cond_valid = 0;
        #1 reset = 1'b0;

        drive(4'b0110, 1, 1);
        step();
        chk("cap_write", flags, 4'b0110);
        drive(4'b1001, 1, 0);
        step();
        chk("cap_no_s", flags, 4'b0110);
        drive(4'b1001, 0, 1);
        step();
        chk("cap_no_valid", flags, 4'b0110);
        drive(4'b0000, 0, 0);

        cond_valid = 1;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            step();
            chk($sformatf("sweep_pass_%0d", i), {3'b0, cond_pass}, {3'b0, sweep_exp[i]});
            chk($sformatf("sweep_valid_%0d", i), {3'b0, cond_pass_valid}, 4'b1);
        end
        cond = 4'b1110;
        step();
        chk("hold_setup", {3'b0, cond_pass}, 4'b1);
        cond_valid = 0;
        cond = 4'b1111;
        step();
        chk("hold_pass", {3'b0, cond_pass}, 4'b1);
        chk("hold_valid", {3'b0, cond_pass_valid}, 4'b0);

        drive(4'b0000, 1, 1);
        step();
        chk("fwd_clear", flags, 4'b0000);
        drive(4'b0100, 1, 1);
        cond = 4'b0000;
        cond_valid = 1;
        step();
        drive(4'b0000, 0, 0);
        cond_valid = 0;
        chk("fwd_pass", {3'b0, cond_pass}, {3'b0, fwd_exp});
        chk("fwd_flags", flags, 4'b0100);

        drive(4'b0001, 1, 1);
        step();
        chk("sticky_set", {3'b0, sticky_v}, 4'b1);
        drive(4'b0000, 1, 1);
        step();
        chk("sticky_hold", {3'b0, sticky_v}, 4'b1);
        drive(4'b0000, 0, 0);
        clear_sticky = 1;
        step();
        chk("sticky_clear", {3'b0, sticky_v}, 4'b0);
        drive(4'b0001, 1, 1);
        step();
        chk("sticky_set_wins", {3'b0, sticky_v}, 4'b1);
        drive(4'b0000, 0, 0);
        step();
        clear_sticky = 0;
        chk("sticky_clear2", {3'b0, sticky_v}, 4'b0);
        drive(4'b0001, 1, 0);
        step();
        chk("sticky_no_s", {3'b0, sticky_v}, 4'b0);

        drive(4'b1001, 1, 1);
        step();
        drive(4'b0000, 0, 0);
        chk("signed_flags", flags, 4'b1001);
        cond_valid = 1;
        cond = 4'b1010; step(); chk("ge_nv", {3'b0, cond_pass}, 4'b1);
        cond = 4'b1011; step(); chk("lt_nv", {3'b0, cond_pass}, 4'b0);
        cond = 4'b1100; step(); chk("gt_nv", {3'b0, cond_pass}, 4'b1);
        cond = 4'b1101; step(); chk("le_nv", {3'b0, cond_pass}, 4'b0);
        cond_valid = 0;
        drive(4'b1000, 1, 1);
        step();
        drive(4'b0000, 0, 0);
        cond_valid = 1;
        cond = 4'b1010; step(); chk("ge_n", {3'b0, cond_pass}, 4'b0);
        cond = 4'b1011; step(); chk("lt_n", {3'b0, cond_pass}, 4'b1);
        cond_valid = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
